imem_loader: RTL

- Writer side of the single-cycle CPU's instruction memory: receives a framed byte stream and writes 32-bit instruction words into a writable instruction RAM.
- The RAM is word-indexed by Address[9:2].
- Holds the CPU stalled until a complete, checksum-verified image is loaded.
- Sits between a byte source (UART receiver or bench) and the instruction RAM write port.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_word_assembler.sv | 57 +++++
 rtl/imem_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: the framing state
// machine encoding, the default frame start marker, the default instruction
// RAM depth and the shift that turns a word index into a byte address.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } loader_state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE   = 8'hA5;
   localparam int         DEFAULT_DEPTH_WORDS = 256;
   localparam int         WORD_ADDR_SHIFT     = 2;

endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler
// Packs incoming data bytes (most significant first) into 32-bit words and
// keeps a running XOR of every data byte seen since the last clear.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   clear        : restart byte position and checksum for a new image
//   byte_valid   : a data byte is being transferred this cycle
//   byte_data    : the data byte
//   last_byte    : the next accepted byte completes a word
//   word_valid   : one-cycle pulse, cycle after a word's 4th byte
//   word         : assembled word (stable while word_valid is high)
//   checksum     : XOR of all data bytes since clear
module imem_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        last_byte,
   output logic        word_valid,
   output logic [31:0] word,
   output logic [7:0]  checksum
);

   logic [1:0] byte_count;

   // The word is complete when three bytes are already held, so the
   // framing FSM can see this before the 4th byte lands.
   assign last_byte = (byte_count == 2'd3);

   // Shift register, byte position and checksum. The word_valid pulse is
   // raised one cycle after the 4th byte; at that point the shift register
   // holds the full word, and a following byte only shifts in at the end of
   // that cycle, so the word stays stable for the whole write strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_count <= 2'd0;
         word       <= 32'd0;
         checksum   <= 8'd0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            byte_count <= 2'd0;
            checksum   <= 8'd0;
         end else if (byte_valid) begin
            word       <= {word[23:0], byte_data};
            checksum   <= checksum ^ byte_data;
            byte_count <= byte_count + 2'd1;
            word_valid <= last_byte;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Receives a framed byte stream (sync, 16-bit big-endian word count, data
// words MSB first, XOR checksum) and writes the words into the instruction
// RAM, holding the CPU until a complete, verified image is in place.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   in_valid   : byte source offers a byte
//   in_data    : offered byte
//   in_ready   : loader accepts the byte this cycle
//   wr_en      : one-cycle instruction RAM write strobe
//   wr_addr    : word-aligned byte address of the write
//   wr_data    : instruction word to write
//   cpu_hold   : CPU held while high
//   done       : image loaded and checksum verified
//   err        : sticky framing/length/checksum error (cleared by reset)
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;

   loader_state_t    state;
   logic [15:0]      len;
   logic [15:0]      len_rx;
   logic [IDX_W-1:0] word_index;
   logic             xfer;
   logic             asm_clear;
   logic             asm_valid;
   logic             last_byte;
   logic             word_valid;
   logic [31:0]      word;
   logic [7:0]       checksum;

   // A byte moves only on a valid/ready handshake. The assembler is cleared
   // on the length low byte so every image starts at byte 0 with a zero
   // checksum, and it only sees bytes that belong to the data section.
   assign xfer      = in_valid && in_ready;
   assign asm_clear = xfer && (state == ST_LEN_LO);
   assign asm_valid = xfer && (state == ST_DATA);
   assign len_rx    = {len[15:8], in_data};

   // The write strobe and word come straight from the assembler registers;
   // the address follows the word index, which only advances after the
   // write cycle so it still names the word being written.
   assign wr_en   = word_valid;
   assign wr_data = word;
   assign wr_addr = 32'(word_index) << WORD_ADDR_SHIFT;

   imem_word_assembler u_assembler (
      .clk        (clk),
      .reset      (reset),
      .clear      (asm_clear),
      .byte_valid (asm_valid),
      .byte_data  (in_data),
      .last_byte  (last_byte),
      .word_valid (word_valid),
      .word       (word),
      .checksum   (checksum)
   );

   // Framing state machine with registered status outputs. The word index
   // steps on every write strobe; the length-low transfer clears it, and
   // since that can never coincide with a strobe the later assignment is
   // only a tie-break in form. When the 4th byte of a word arrives the
   // index still equals that word's number, so comparing it with N-1 finds
   // the last word. ERR drops in_ready, so nothing more is accepted there.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         in_ready   <= 1'b1;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         len        <= 16'd0;
         word_index <= '0;
      end else begin
         if (word_valid) begin
            word_index <= word_index + IDX_W'(1);
         end
         if (xfer) begin
            case (state)
               ST_IDLE: begin
                  if (in_data == SYNC_BYTE) begin
                     state <= ST_LEN_HI;
                  end
               end
               ST_LEN_HI: begin
                  len[15:8] <= in_data;
                  state     <= ST_LEN_LO;
               end
               ST_LEN_LO: begin
                  len[7:0]   <= in_data;
                  word_index <= '0;
                  if (len_rx > 16'(DEPTH_WORDS)) begin
                     state    <= ST_ERR;
                     err      <= 1'b1;
                     in_ready <= 1'b0;
                  end else if (len_rx == 16'd0) begin
                     state <= ST_CSUM;
                  end else begin
                     state <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (last_byte && (16'(word_index) == len - 16'd1)) begin
                     state <= ST_CSUM;
                  end
               end
               ST_CSUM: begin
                  if (in_data == checksum) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state    <= ST_ERR;
                     err      <= 1'b1;
                     in_ready <= 1'b0;
                  end
               end
               ST_DONE: begin
                  if (in_data == SYNC_BYTE) begin
                     state    <= ST_LEN_HI;
                     cpu_hold <= 1'b1;
                     done     <= 1'b0;
                  end
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end

endmodule
